// File: rtl/pong_engine.sv
// Pong game-state engine: owns ball, paddles, scores and game phase, and advances
// them once per frame tick. Every output is a register.
module pong_engine #(
    parameter int COLS        = 16,
    parameter int ROWS        = 8,
    parameter int PADDLE_LEN  = 3,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 4,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          p1_up,
    input  logic          p1_dn,
    input  logic          p2_up,
    input  logic          p2_dn,
    output logic [XW-1:0] b_x,
    output logic [YW-1:0] b_y,
    output logic [YW-1:0] p1_y,
    output logic [YW-1:0] p2_y,
    output logic [SW-1:0] p1,
    output logic [SW-1:0] p2,
    output logic [2:0]    state,
    output logic [1:0]    winner,
    output logic          upd
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [XW-1:0] X_MID  = XW'(COLS / 2);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [XW-1:0] X_P2   = XW'(COLS - 2);
    localparam logic [XW-1:0] X_P2M  = XW'(COLS - 3);
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MID  = YW'(ROWS / 2);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [YW-1:0] P_MID  = YW'((ROWS - PADDLE_LEN) / 2);
    localparam logic [YW-1:0] P_MAX  = YW'(ROWS - PADDLE_LEN);
    localparam logic [SW-1:0] WIN    = SW'(WIN_SCORE);
    localparam logic [7:0]    SRV    = 8'(SERVE_TICKS);

    state_t        cur, nxt;
    logic [XW-1:0] bx_n;
    logic [YW-1:0] by_n, py1_n, py2_n;
    logic [SW-1:0] s1_n, s2_n;
    logic [1:0]    win_n;
    logic          upd_n;
    // dx_neg/dy_neg set means the ball moves toward lower column/row
    logic          dx_neg, dy_neg, dx_n, dy_n;
    logic          p1_scored, scored_n;
    logic [7:0]    cnt, cnt_n;

    function automatic logic [YW-1:0] paddle_move(input logic [YW-1:0] y, input logic up,
                                                  input logic dn);
        paddle_move = y;
        if (up && !dn && y != '0)
            paddle_move = y - 1'b1;
        else if (dn && !up && y < P_MAX)
            paddle_move = y + 1'b1;
    endfunction

    function automatic logic covers(input logic [YW-1:0] py, input logic [YW-1:0] y);
        covers = (int'(y) >= int'(py)) && (int'(y) <= int'(py) + PADDLE_LEN - 1);
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
        sat_inc = (s < WIN) ? s + 1'b1 : s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= IDLE;
            b_x       <= X_MID;
            b_y       <= Y_MID;
            p1_y      <= P_MID;
            p2_y      <= P_MID;
            p1        <= '0;
            p2        <= '0;
            winner    <= 2'd0;
            upd       <= 1'b0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            p1_scored <= 1'b0;
            cnt       <= '0;
        end else begin
            cur       <= nxt;
            b_x       <= bx_n;
            b_y       <= by_n;
            p1_y      <= py1_n;
            p2_y      <= py2_n;
            p1        <= s1_n;
            p2        <= s2_n;
            winner    <= win_n;
            upd       <= upd_n;
            dx_neg    <= dx_n;
            dy_neg    <= dy_n;
            p1_scored <= scored_n;
            cnt       <= cnt_n;
        end
    end

    assign state = cur;

    always_comb begin
        nxt      = cur;
        bx_n     = b_x;
        by_n     = b_y;
        py1_n    = p1_y;
        py2_n    = p2_y;
        s1_n     = p1;
        s2_n     = p2;
        win_n    = winner;
        upd_n    = 1'b0;
        dx_n     = dx_neg;
        dy_n     = dy_neg;
        scored_n = p1_scored;
        cnt_n    = cnt;
        case (cur)
            IDLE: begin
                if (start) begin
                    nxt   = SERVE;
                    cnt_n = '0;
                end
            end
            SERVE: begin
                if (tick) begin
                    upd_n = 1'b1;
                    py1_n = paddle_move(p1_y, p1_up, p1_dn);
                    py2_n = paddle_move(p2_y, p2_up, p2_dn);
                    cnt_n = cnt + 8'd1;
                    if (cnt + 8'd1 >= SRV)
                        nxt = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    upd_n = 1'b1;
                    py1_n = paddle_move(p1_y, p1_up, p1_dn);
                    py2_n = paddle_move(p2_y, p2_up, p2_dn);
                    if (b_y == '0 && dy_neg) begin
                        dy_n = 1'b0;
                        by_n = Y_ONE;
                    end else if (b_y == Y_LAST && !dy_neg) begin
                        dy_n = 1'b1;
                        by_n = Y_LAST - 1'b1;
                    end else begin
                        by_n = dy_neg ? b_y - 1'b1 : b_y + 1'b1;
                    end
                    // Hit tests use the paddle rows from before this tick's move
                    if (dx_neg && b_x == X_ONE) begin
                        if (covers(p1_y, b_y)) begin
                            dx_n = 1'b0;
                            bx_n = X_TWO;
                        end else begin
                            bx_n     = '0;
                            s2_n     = sat_inc(p2);
                            scored_n = 1'b0;
                            nxt      = POINT;
                        end
                    end else if (!dx_neg && b_x == X_P2) begin
                        if (covers(p2_y, b_y)) begin
                            dx_n = 1'b1;
                            bx_n = X_P2M;
                        end else begin
                            bx_n     = X_LAST;
                            s1_n     = sat_inc(p1);
                            scored_n = 1'b1;
                            nxt      = POINT;
                        end
                    end else begin
                        bx_n = dx_neg ? b_x - 1'b1 : b_x + 1'b1;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    upd_n = 1'b1;
                    if (p1_scored ? (p1 == WIN) : (p2 == WIN)) begin
                        nxt   = OVER;
                        win_n = p1_scored ? 2'd1 : 2'd2;
                    end else begin
                        nxt   = SERVE;
                        bx_n  = X_MID;
                        by_n  = Y_MID;
                        dx_n  = !p1_scored;
                        cnt_n = '0;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    nxt   = SERVE;
                    bx_n  = X_MID;
                    by_n  = Y_MID;
                    py1_n = P_MID;
                    py2_n = P_MID;
                    s1_n  = '0;
                    s2_n  = '0;
                    win_n = 2'd0;
                    dx_n  = 1'b0;
                    dy_n  = 1'b0;
                    cnt_n = '0;
                end
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: doc/pong_engine.md
# pong_engine

Game-state engine for the LED-matrix Pong. It owns ball position and direction, both paddle positions, and both player scores, and advances them once per frame tick from the player buttons. It produces exactly the position and score signals that the init/reset logic and the matrix renderer consume, so it is the writer side of the game-state interface.

## Interface
- COLS, 16: matrix width; paddle 1 in column 0, paddle 2 in column COLS-1
- ROWS, 8: matrix height
- PADDLE_LEN, 3: paddle height in rows
- WIN_SCORE, 7: score that ends the game
- SERVE_TICKS, 4: ticks spent in SERVE before play
- XW = clog2(COLS), YW = clog2(ROWS), SW = 4 (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle frame-step pulse
- start  in  1  start/restart request, sampled each cycle
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  paddle buttons, level
- b_x  out  XW  ball column
- b_y  out  YW  ball row
- p1_y, p2_y  out  YW  top row of each paddle
- p1, p2  out  SW  scores
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- winner  out  2  0 none, 1 player 1, 2 player 2
- upd  out  1  one-cycle pulse after each processed tick

## Operation
- Reset values:
  - b_x=COLS/2 (8), b_y=ROWS/2 (4)
  - p1_y=p2_y=(ROWS-PADDLE_LEN)/2 (2)
  - scores 0, dx=+1, dy=+1
  - state IDLE, winner 0, upd 0, serve counter 0
- IDLE: start -> SERVE, counter cleared. Ticks are ignored.
- Paddles (SERVE and PLAY, on tick):
  - up alone: y-1 if y>0.
  - down alone: y+1 if y<ROWS-PADDLE_LEN.
  - both or neither: hold.
- SERVE: each tick increments the counter. When the counter reaches SERVE_TICKS -> PLAY. The ball holds at centre.
- PLAY, on tick (each axis independent; all checks use pre-tick values):
  - Y axis: if b_y=0 with dy=-1, or b_y=ROWS-1 with dy=+1, negate dy and move one row the new way. Otherwise ny=b_y+dy.
  - X axis, dx=-1 and b_x=1: if p1_y<=b_y<=p1_y+PADDLE_LEN-1 it is a hit: dx=+1, nx=2. Otherwise it is a miss: nx=0, p2+1, -> POINT.
  - X axis, dx=+1 and b_x=COLS-2: mirrored against p2_y. A miss gives nx=COLS-1, p1+1, -> POINT.
  - X axis, otherwise: nx=b_x+dx.
  - The hit test uses the paddle position before this tick's paddle move.
- POINT: the ball is shown in the goal column for one tick. On the next tick:
  - If the scorer's score = WIN_SCORE -> OVER, winner set.
  - Otherwise -> SERVE: ball recentred, dx pointed toward the conceding player, dy kept, counter cleared.
  - Paddles do not move in POINT.
- OVER: outputs frozen. start -> scores 0, winner 0, ball and paddles at reset values, -> SERVE.
- start is ignored in SERVE, PLAY and POINT.
- Scores saturate at WIN_SCORE.

## Timing
- All outputs are registered and update on the clk edge that samples tick=1. New values are visible the next cycle.
- upd=1 for exactly the cycle after any tick sampled in SERVE, PLAY or POINT. It is never set in IDLE or OVER.
- start and tick in the same cycle in IDLE or OVER: start is taken and the tick is dropped, so there is no upd.
- Back-to-back ticks every cycle are legal and give one step per cycle.
- rst asserted at any point, including mid-tick: all outputs return to reset values immediately, with no clock needed. Operation resumes on the first edge after rst drops.

## Test plan
- Reset: after rst, check b=(8,4), p1_y=p2_y=2, p1=p2=0, state=0, winner=0, upd=0. Ticks with no start keep state=0 and upd=0.
- Serve and hit:
  - start, then 4 ticks: state=2.
  - 6 more ticks: ball path (9,5),(10,6),(11,7),(12,6),(13,5),(14,4).
  - Next tick with p2_y=2: hit, ball (13,3), dx=-1.
- Miss and score:
  - Hold p2_dn for the 4 serve ticks plus 6 play ticks: p2_y saturates at 5.
  - Next tick: ball (15,3), state=3, p1=1.
  - Next tick: state=1, ball (8,4), dx=+1.
- Win: with WIN_SCORE=1, run the miss scenario. The tick after POINT gives state=4, winner=1. Further ticks change nothing. start gives p1=0, state=1.
- Corner bounce and paddle limits:
  - Ball at (1,0), dx=-1, dy=-1, p1_y=0 -> hit, ball (2,1), dx=+1, dy=+1.
  - Both buttons held: paddle holds.
  - p1_up at y=0: paddle holds.
- Async reset mid-PLAY: assert rst between edges. Outputs take reset values before the next edge, and state=0.
